// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory pipeline stage behind EX. Non-memory instructions are
//            registered straight through to WB with one cycle of latency.
//            Loads/stores run a req/gnt/rvalid bus access and stall EX until
//            the response returns. Every output is driven from a register.
// Ports    : clk, rst_n              - clock, async active-low reset
//            ex_valid_i / ex_ready_o - EX handshake (ready only in IDLE)
//            instr_i, rd_idx_i, rd_en_i, alu_ret_i, rs2_rdata_i - EX bundle
//            dbus_*                  - data bus request / response
//            wb_*                    - one-cycle writeback bundle
//            mem_misalign_o, mem_badaddr_o - only with MEM_MISALIGN_CHECK_EN
// Options  : MEM_MISALIGN_CHECK_EN - trap misaligned half/word accesses
//            instead of issuing them on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int XLEN          = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid_i,
  output logic                     ex_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx_i,
  input  logic                     rd_en_i,
  input  logic [XLEN-1:0]          alu_ret_i,
  input  logic [XLEN-1:0]          rs2_rdata_i,
  output logic                     dbus_req_o,
  output logic                     dbus_we_o,
  output logic [XLEN-1:0]          dbus_addr_o,
  output logic [XLEN-1:0]          dbus_wdata_o,
  output logic [3:0]               dbus_be_o,
  input  logic                     dbus_gnt_i,
  input  logic                     dbus_rvalid_i,
  input  logic [XLEN-1:0]          dbus_rdata_i,
  output logic                     wb_valid_o,
  output logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o,
  output logic                     wb_rd_en_o,
  output logic [XLEN-1:0]          wb_rdata_o
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                     mem_misalign_o,
  output logic [XLEN-1:0]          mem_badaddr_o
`endif
);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;

  logic [1:0] r_state, w_state_next;

  // Access attributes captured at acceptance, used when the response returns
  logic [2:0]               r_fun3;
  logic [1:0]               r_alo;
  logic [REG_IDX_WIDTH-1:0] r_rd_idx;
  logic                     r_rd_en;
  logic                     r_is_store;

  // Decode of the incoming instruction
  logic       w_is_load, w_is_store, w_is_mem, w_misalign;
  logic [2:0] w_fun3;
  logic [1:0] w_alo;
  logic       w_unused;

  assign w_fun3     = instr_i[14:12];
  assign w_alo      = alu_ret_i[1:0];
  assign w_is_load  = (instr_i[6:0] == c_op_load);
  assign w_is_store = (instr_i[6:0] == c_op_store);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_unused   = &{1'b0, instr_i[31:15], instr_i[11:7]};

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = ((w_fun3[1:0] == 2'b01) & w_alo[0]) |
                      (w_fun3[1] & (w_alo != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Byte enables and lane-replicated store data; fun3[1:0] gives the size
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_rdata_i;
    case (w_fun3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_alo;
        w_wdata = {(XLEN/8){rs2_rdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = w_alo[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(XLEN/16){rs2_rdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the latched lane; fun3[2] selects zero extension
  logic [7:0]      w_lbyte;
  logic [15:0]     w_lhalf;
  logic [XLEN-1:0] w_load_data;

  assign w_lbyte = dbus_rdata_i[{r_alo, 3'b000} +: 8];
  assign w_lhalf = dbus_rdata_i[{r_alo[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = dbus_rdata_i;
    case (r_fun3)
      3'b000:  w_load_data = {{(XLEN-8){w_lbyte[7]}}, w_lbyte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_lbyte};
      3'b001:  w_load_data = {{(XLEN-16){w_lhalf[15]}}, w_lhalf};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_lhalf};
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (ex_valid_i && w_is_mem && !w_misalign) w_state_next = c_st_req;
      c_st_req:  if (dbus_gnt_i)    w_state_next = c_st_wait;
      c_st_wait: if (dbus_rvalid_i) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // ------------------------------------------------- next values of outputs
  logic                     w_req_d, w_we_d, w_wb_valid_d, w_wb_rd_en_d, w_latch;
  logic                     w_misalign_d;
  logic [XLEN-1:0]          w_addr_d, w_wdata_d, w_wb_rdata_d;
  logic [3:0]               w_be_d;
  logic [REG_IDX_WIDTH-1:0] w_wb_rd_idx_d;

  always_comb begin
    // Bus and WB data fields hold by default; only the valid pulses clear
    w_req_d       = dbus_req_o;
    w_we_d        = dbus_we_o;
    w_addr_d      = dbus_addr_o;
    w_wdata_d     = dbus_wdata_o;
    w_be_d        = dbus_be_o;
    w_wb_valid_d  = 1'b0;
    w_wb_rd_idx_d = wb_rd_idx_o;
    w_wb_rd_en_d  = wb_rd_en_o;
    w_wb_rdata_d  = wb_rdata_o;
    w_latch       = 1'b0;
    w_misalign_d  = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (ex_valid_i) begin
          w_wb_rd_idx_d = rd_idx_i;
          if (!w_is_mem) begin
            w_wb_valid_d = 1'b1;
            w_wb_rd_en_d = rd_en_i;
            w_wb_rdata_d = alu_ret_i;
          end else if (w_misalign) begin
            // Trapped access: retire without a bus request or a reg write
            w_wb_valid_d = 1'b1;
            w_wb_rd_en_d = 1'b0;
            w_wb_rdata_d = '0;
            w_misalign_d = 1'b1;
          end else begin
            w_latch   = 1'b1;
            w_req_d   = 1'b1;
            w_we_d    = w_is_store;
            w_addr_d  = {alu_ret_i[XLEN-1:2], 2'b00};
            w_be_d    = w_be;
            w_wdata_d = w_wdata;
          end
        end
      end
      c_st_req: if (dbus_gnt_i) w_req_d = 1'b0;
      c_st_wait: begin
        if (dbus_rvalid_i) begin
          w_wb_valid_d  = 1'b1;
          w_wb_rd_idx_d = r_rd_idx;
          w_wb_rd_en_d  = r_is_store ? 1'b0 : r_rd_en;
          w_wb_rdata_d  = r_is_store ? '0 : w_load_data;
        end
      end
      default: w_req_d = 1'b0;
    endcase
  end

  assign ex_ready_o = (r_state == c_st_idle);

  // --------------------------------------------------------- output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wdata_o <= '0;
      dbus_be_o    <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_idx_o  <= '0;
      wb_rd_en_o   <= 1'b0;
      wb_rdata_o   <= '0;
      r_fun3       <= '0;
      r_alo        <= '0;
      r_rd_idx     <= '0;
      r_rd_en      <= 1'b0;
      r_is_store   <= 1'b0;
    end else begin
      dbus_req_o   <= w_req_d;
      dbus_we_o    <= w_we_d;
      dbus_addr_o  <= w_addr_d;
      dbus_wdata_o <= w_wdata_d;
      dbus_be_o    <= w_be_d;
      wb_valid_o   <= w_wb_valid_d;
      wb_rd_idx_o  <= w_wb_rd_idx_d;
      wb_rd_en_o   <= w_wb_rd_en_d;
      wb_rdata_o   <= w_wb_rdata_d;
      if (w_latch) begin
        r_fun3     <= w_fun3;
        r_alo      <= w_alo;
        r_rd_idx   <= rd_idx_i;
        r_rd_en    <= rd_en_i;
        r_is_store <= w_is_store;
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_misalign_o <= 1'b0;
      mem_badaddr_o  <= '0;
    end else begin
      mem_misalign_o <= w_misalign_d;
      if (w_misalign_d) mem_badaddr_o <= alu_ret_i;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Expected writeback bundles
//            are queued when an instruction is driven and compared by a
//            monitor whenever wb_valid_o is seen.
// Options  : MEM_MISALIGN_CHECK_EN - also exercises the misalignment trap
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_imm   = 7'b0010011;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid_i = 1'b0;
  logic            ex_ready_o;
  logic [31:0]     instr_i = '0;
  logic [RW-1:0]   rd_idx_i = '0;
  logic            rd_en_i = 1'b0;
  logic [XLEN-1:0] alu_ret_i = '0;
  logic [XLEN-1:0] rs2_rdata_i = '0;
  logic            dbus_req_o, dbus_we_o;
  logic [XLEN-1:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]      dbus_be_o;
  logic            dbus_gnt_i = 1'b0;
  logic            dbus_rvalid_i = 1'b0;
  logic [XLEN-1:0] dbus_rdata_i = '0;
  logic            wb_valid_o, wb_rd_en_o;
  logic [RW-1:0]   wb_rd_idx_o;
  logic [XLEN-1:0] wb_rdata_o;
`ifdef MEM_MISALIGN_CHECK_EN
  logic            mem_misalign_o;
  logic [XLEN-1:0] mem_badaddr_o;
`endif

  mem_stage #(.XLEN(XLEN), .REG_IDX_WIDTH(RW)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .instr_i       (instr_i),
    .rd_idx_i      (rd_idx_i),
    .rd_en_i       (rd_en_i),
    .alu_ret_i     (alu_ret_i),
    .rs2_rdata_i   (rs2_rdata_i),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_idx_o   (wb_rd_idx_o),
    .wb_rd_en_o    (wb_rd_en_o),
    .wb_rdata_o    (wb_rdata_o)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .mem_misalign_o(mem_misalign_o),
    .mem_badaddr_o (mem_badaddr_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [RW-1:0]   idx;
    logic            en;
    logic [XLEN-1:0] data;
    logic            chk_data;
    int              cyc;
  } wb_exp_t;

  wb_exp_t sb[$];

  // Writeback monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && wb_valid_o) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'd1, 64'd0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_rd_idx", 64'(wb_rd_idx_o), 64'(e.idx));
        check("wb_rd_en", 64'(wb_rd_en_o), 64'(e.en));
        if (e.chk_data) check("wb_rdata", 64'(wb_rdata_o), 64'(e.data));
        check("wb_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drive one instruction at a negedge; it is accepted at the next posedge
  task automatic drive_ex(input logic [6:0] op, input logic [2:0] f3, input logic [RW-1:0] rd,
                          input logic en, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rs2);
    ex_valid_i  = 1'b1;
    instr_i     = {17'd0, f3, 5'd0, op};
    rd_idx_i    = rd;
    rd_en_i     = en;
    alu_ret_i   = alu;
    rs2_rdata_i = rs2;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu_op(input logic [RW-1:0] rd, input logic en, input logic [XLEN-1:0] res);
    sb.push_back('{idx: rd, en: en, data: res, chk_data: 1'b1, cyc: cyc + 1});
    drive_ex(c_op_imm, 3'b000, rd, en, res, 32'h0);
    step();
    check("alu_ready", 64'(ex_ready_o), 64'd1);
  endtask

  // Full load/store with gd cycles of grant hold-off and rd cycles before rvalid
  task automatic mem_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rs2,
                        input logic [XLEN-1:0] rdata, input int gd, input int rdl,
                        input logic [XLEN-1:0] e_addr, input logic [3:0] e_be,
                        input logic [XLEN-1:0] e_wdata, input logic [XLEN-1:0] e_wb,
                        input logic [RW-1:0] rd, input logic en);
    sb.push_back('{idx: rd, en: (st ? 1'b0 : en), data: e_wb, chk_data: !st,
                   cyc: cyc + 3 + gd + rdl});
    drive_ex(st ? c_op_store : c_op_load, f3, rd, en, alu, rs2);
    step();
    ex_valid_i = 1'b0;
    for (int i = 0; i <= gd; i++) begin
      check({tag, "_req"}, 64'(dbus_req_o), 64'd1);
      check({tag, "_addr"}, 64'(dbus_addr_o), 64'(e_addr));
      check({tag, "_be"}, 64'(dbus_be_o), 64'(e_be));
      check({tag, "_we"}, 64'(dbus_we_o), 64'(st));
      if (st) check({tag, "_wdata"}, 64'(dbus_wdata_o), 64'(e_wdata));
      check({tag, "_ready_req"}, 64'(ex_ready_o), 64'd0);
      if (i == gd) dbus_gnt_i = 1'b1;
      else begin
        // A stray response while still requesting must be ignored
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = ~rdata;
      end
      step();
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
    end
    check({tag, "_req_drop"}, 64'(dbus_req_o), 64'd0);
    check({tag, "_ready_wait"}, 64'(ex_ready_o), 64'd0);
    for (int i = 0; i < rdl; i++) step();
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = rdata;
    step();
    dbus_rvalid_i = 1'b0;
    check({tag, "_ready_done"}, 64'(ex_ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 64'(dbus_req_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_addr", 64'(dbus_addr_o), 64'd0);
    check("rst_wb_rdata", 64'(wb_rdata_o), 64'd0);
    check("rst_wb_rd_en", 64'(wb_rd_en_o), 64'd0);
    check("rst_ready", 64'(ex_ready_o), 64'd1);
    rst_n = 1'b1;
    step();

    // Back-to-back ALU results
    alu_op(5'd5, 1'b1, 32'h0000_0055);
    alu_op(5'd6, 1'b0, 32'hDEAD_BEEF);
    ex_valid_i = 1'b0;
    step();

    //     tag    st  f3      addr          rs2           rdata         gd rdl e_addr        be       wdata         wb            rd     en
    mem_op("lb",  0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 5'd10, 1'b1);
    mem_op("sh",  1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        4, 0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        5'd7,  1'b1);
    mem_op("lhu", 0, 3'b101, 32'h0000_3002, 32'h0,        32'h8001_0000, 0, 1, 32'h0000_3000, 4'b1100, 32'h0,        32'h0000_8001, 5'd11, 1'b1);
    mem_op("lh",  0, 3'b001, 32'h0000_3000, 32'h0,        32'h0000_8001, 1, 0, 32'h0000_3000, 4'b0011, 32'h0,        32'hFFFF_8001, 5'd12, 1'b1);
    mem_op("sb",  1, 3'b000, 32'h0000_5001, 32'h0000_00EF, 32'h0,        0, 2, 32'h0000_5000, 4'b0010, 32'hEFEF_EFEF, 32'h0,        5'd13, 1'b0);
    mem_op("lw",  0, 3'b010, 32'h0000_6000, 32'h0,        32'hCAFE_F00D, 0, 0, 32'h0000_6000, 4'b1111, 32'h0,        32'hCAFE_F00D, 5'd14, 1'b1);
    mem_op("lbu", 0, 3'b100, 32'h0000_6001, 32'h0,        32'h0000_9C00, 0, 0, 32'h0000_6000, 4'b0010, 32'h0,        32'h0000_009C, 5'd15, 1'b1);
    mem_op("sw",  1, 3'b010, 32'h0000_7004, 32'h1357_9BDF, 32'h0,        1, 1, 32'h0000_7004, 4'b1111, 32'h1357_9BDF, 32'h0,        5'd16, 1'b1);

    // Reset in the middle of an access: nothing may be written back
    drive_ex(c_op_load, 3'b010, 5'd20, 1'b1, 32'h0000_8000, 32'h0);
    step();
    ex_valid_i = 1'b0;
    dbus_gnt_i = 1'b1;
    step();
    dbus_gnt_i = 1'b0;
    check("mid_in_wait", 64'(ex_ready_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 64'(dbus_req_o), 64'd0);
    check("mid_rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("mid_rst_ready", 64'(ex_ready_o), 64'd1);
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h1111_1111;
    step();
    dbus_rvalid_i = 1'b0;
    rst_n = 1'b1;
    step();
    alu_op(5'd3, 1'b1, 32'h0000_0123);
    ex_valid_i = 1'b0;
    step();

`ifdef MEM_MISALIGN_CHECK_EN
    sb.push_back('{idx: 5'd9, en: 1'b0, data: 32'h0, chk_data: 1'b0, cyc: cyc + 1});
    drive_ex(c_op_load, 3'b010, 5'd9, 1'b1, 32'h0000_4001, 32'h0);
    step();
    ex_valid_i = 1'b0;
    check("mis_req", 64'(dbus_req_o), 64'd0);
    check("mis_pulse", 64'(mem_misalign_o), 64'd1);
    check("mis_badaddr", 64'(mem_badaddr_o), 64'h4001);
    check("mis_ready", 64'(ex_ready_o), 64'd1);
    step();
    check("mis_pulse_end", 64'(mem_misalign_o), 64'd0);
    check("mis_req_after", 64'(dbus_req_o), 64'd0);
`endif

    repeat (3) step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
